// File: rtl/axi_lite_read_arbiter_if.sv
// axi_lite_read_arbiter_if: AXI4-Lite read-channel bundle (AR + R) shared by masters and the slave link.
interface axi_lite_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              AR_VALID;
  logic              AR_READY;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              R_VALID;
  logic              R_READY;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  modport master (
    output AR_VALID, AR_ADDR, R_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP
  );
  modport slave (
    input  AR_VALID, AR_ADDR, R_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi_lite_read_arbiter.sv
// axi_lite_read_arbiter: two-master to one-slave AXI4-Lite read arbiter, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin on contested grants; otherwise M0 has fixed priority.
module axi_lite_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  axi_lite_read_arbiter_if.slave  m0,
  axi_lite_read_arbiter_if.slave  m1,
  axi_lite_read_arbiter_if.master s,
  output logic                    GRANT,
  output logic                    BUSY
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              req, win, grab, in_addr, in_data, r_done, sel0, sel1;
  logic [DATA_W-1:0] r_data;
  assign req     = m0.AR_VALID | m1.AR_VALID;
`ifdef ARB_ROUND_ROBIN_EN
  // Contested grants go to whichever master was not served last.
  assign win     = (m0.AR_VALID & m1.AR_VALID) ? ~last_q : m1.AR_VALID;
`else
  assign win     = ~m0.AR_VALID;
`endif
  assign grab    = (state_q == IDLE) & req;
  assign in_addr = state_q == ADDR;
  assign in_data = state_q == DATA;
  assign sel0    = in_data & ~grant_q;
  assign sel1    = in_data & grant_q;
  assign r_data  = s.R_DATA;
  assign r_done  = in_data & s.R_VALID & s.R_READY;
  assign m0.AR_READY = grab & ~win;
  assign m1.AR_READY = grab & win;
  assign m0.R_VALID  = sel0 & s.R_VALID;
  assign m0.R_DATA   = sel0 ? r_data : '0;
  assign m0.R_RESP   = sel0 ? s.R_RESP : 2'b00;
  assign m1.R_VALID  = sel1 & s.R_VALID;
  assign m1.R_DATA   = sel1 ? r_data : '0;
  assign m1.R_RESP   = sel1 ? s.R_RESP : 2'b00;
  assign s.R_READY   = sel0 ? m0.R_READY : sel1 & m1.R_READY;
  assign s.AR_VALID  = ar_valid_q;
  assign s.AR_ADDR   = ar_addr_q;
  assign GRANT       = grant_q;
  assign BUSY        = in_addr | in_data;
  always_comb begin
    state_d    = grab ? ADDR :
                 in_addr ? ((ar_valid_q & s.AR_READY) ? DATA : ADDR) :
                 in_data ? (r_done ? IDLE : DATA) : IDLE;
    ar_valid_d = grab | (ar_valid_q & ~s.AR_READY);
    ar_addr_d  = grab ? (win ? m1.AR_ADDR : m0.AR_ADDR) : ar_addr_q;
    grant_d    = grab ? win : grant_q;
    last_d     = grab ? win : last_q;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// tb_axi_lite_read_arbiter: directed plus randomized checks of the read arbiter against a grant-rule model.
module tb_axi_lite_read_arbiter;
  logic ACLK = 1'b0;
  logic ARESET;
  logic GRANT, BUSY;
  int   checks = 0;
  int   errors = 0;
  logic last_m = 1'b1;
  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_lite_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  axi_lite_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .m0(m0_if), .m1(m1_if), .s(s_if), .GRANT(GRANT), .BUSY(BUSY)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask
  task automatic chkw(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask
  // Expected winner from the arbitration rule alone.
  function automatic logic pick(logic v0, logic v1, logic last);
`ifdef ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ~last;
    return v1;
`else
    return !v0;
`endif
  endfunction
  // One complete transaction starting in IDLE with at least one master requesting.
  task automatic serve(int ar_dly, int r_dly, int rr_dly, logic [31:0] data, logic [1:0] resp);
    logic        w;
    logic [31:0] a;
    w = pick(m0_if.AR_VALID, m1_if.AR_VALID, last_m);
    a = w ? m1_if.AR_ADDR : m0_if.AR_ADDR;
    s_if.AR_READY = 1'b0;
    s_if.R_VALID  = 1'b0;
    m0_if.R_READY = 1'b1;
    m1_if.R_READY = 1'b1;
    #1;
    chk1("m0_ar_ready_grant", m0_if.AR_READY, !w);
    chk1("m1_ar_ready_grant", m1_if.AR_READY, w);
    tick;
    last_m = w;
    if (w) begin m1_if.AR_VALID = 1'b0; m1_if.AR_ADDR = $urandom; end
    else begin m0_if.AR_VALID = 1'b0; m0_if.AR_ADDR = $urandom; end
    s_if.R_VALID = 1'b1;
    s_if.R_DATA  = $urandom;
    for (int i = 0; i <= ar_dly; i++) begin
      s_if.AR_READY = (i == ar_dly);
      #1;
      chk1("s_ar_valid", s_if.AR_VALID, 1'b1);
      chkw("s_ar_addr", s_if.AR_ADDR, a);
      chk1("grant", GRANT, w);
      chk1("busy_addr", BUSY, 1'b1);
      chk1("no_ar_ready", m0_if.AR_READY | m1_if.AR_READY, 1'b0);
      chk1("stray_r_valid", m0_if.R_VALID | m1_if.R_VALID, 1'b0);
      chk1("s_r_ready_addr", s_if.R_READY, 1'b0);
      tick;
    end
    s_if.AR_READY = 1'b0;
    s_if.R_VALID  = 1'b0;
    chk1("s_ar_valid_clr", s_if.AR_VALID, 1'b0);
    for (int i = 0; i < r_dly; i++) begin
      #1;
      chk1("r_valid_wait", m0_if.R_VALID | m1_if.R_VALID, 1'b0);
      chk1("busy_data", BUSY, 1'b1);
      tick;
    end
    s_if.R_VALID = 1'b1;
    s_if.R_DATA  = data;
    s_if.R_RESP  = resp;
    for (int i = 0; i <= rr_dly; i++) begin
      if (w) m1_if.R_READY = (i == rr_dly); else m0_if.R_READY = (i == rr_dly);
      #1;
      chk1("win_r_valid", w ? m1_if.R_VALID : m0_if.R_VALID, 1'b1);
      chkw("win_r_data", w ? m1_if.R_DATA : m0_if.R_DATA, data);
      chkw("win_r_resp", 32'(w ? m1_if.R_RESP : m0_if.R_RESP), 32'(resp));
      chk1("lose_r_valid", w ? m0_if.R_VALID : m1_if.R_VALID, 1'b0);
      chkw("lose_r_data", w ? m0_if.R_DATA : m1_if.R_DATA, 32'h0);
      chk1("s_r_ready", s_if.R_READY, i == rr_dly);
      chk1("grant_data", GRANT, w);
      tick;
    end
    s_if.R_VALID  = 1'b0;
    m0_if.R_READY = 1'b1;
    m1_if.R_READY = 1'b1;
    #1;
    chk1("busy_idle", BUSY, 1'b0);
  endtask
  initial begin
    ARESET = 1'b1;
    m0_if.AR_VALID = 1'b0; m0_if.AR_ADDR = '0; m0_if.R_READY = 1'b0;
    m1_if.AR_VALID = 1'b0; m1_if.AR_ADDR = '0; m1_if.R_READY = 1'b0;
    s_if.AR_READY = 1'b0; s_if.R_VALID = 1'b0; s_if.R_DATA = '0; s_if.R_RESP = 2'b00;
    tick;
    tick;
    chk1("rst_s_ar_valid", s_if.AR_VALID, 1'b0);
    chkw("rst_s_ar_addr", s_if.AR_ADDR, 32'h0);
    chk1("rst_grant", GRANT, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_s_r_ready", s_if.R_READY, 1'b0);
    ARESET = 1'b0;
    tick;
    // single M0 fetch with immediate slave
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h0000_0010;
    serve(0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    // contested requests: 0x4 from M0, 0x8 from M1, M0 re-requests after its first grant
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h4;
    m1_if.AR_VALID = 1'b1; m1_if.AR_ADDR = 32'h8;
    serve(0, 0, 0, 32'h0000_0004, 2'b00);
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h4;
    serve(0, 0, 0, 32'h0000_0008, 2'b00);
    while (m0_if.AR_VALID || m1_if.AR_VALID) serve(0, 1, 0, $urandom, 2'b00);
    // slave stalls AR for five cycles
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h0000_0100;
    serve(5, 0, 0, 32'hCAFE_F00D, 2'b00);
    // M1 holds R_READY low for three cycles
    m1_if.AR_VALID = 1'b1; m1_if.AR_ADDR = 32'h0000_0200;
    serve(0, 0, 3, 32'h1234_5678, 2'b10);
    // reset in the middle of DATA
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h0000_0020;
    s_if.AR_READY = 1'b1;
    tick;
    m0_if.AR_VALID = 1'b0;
    tick;
    s_if.R_VALID = 1'b1; s_if.R_DATA = 32'hAAAA_5555; m0_if.R_READY = 1'b0;
    #1;
    chk1("pre_rst_r_valid", m0_if.R_VALID, 1'b1);
    #2;
    ARESET = 1'b1;
    #1;
    chk1("arst_busy", BUSY, 1'b0);
    chk1("arst_grant", GRANT, 1'b0);
    chk1("arst_s_ar_valid", s_if.AR_VALID, 1'b0);
    chkw("arst_s_ar_addr", s_if.AR_ADDR, 32'h0);
    chk1("arst_m0_r_valid", m0_if.R_VALID, 1'b0);
    chk1("arst_s_r_ready", s_if.R_READY, 1'b0);
    last_m = 1'b1;
    s_if.R_VALID = 1'b0; s_if.AR_READY = 1'b0;
    tick;
    ARESET = 1'b0;
    tick;
    m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = 32'h0000_0030;
    serve(0, 0, 0, 32'h0BAD_CAFE, 2'b01);
    // randomized traffic; pending requests stay asserted until granted
    for (int n = 0; n < 40; n++) begin
      if (!m0_if.AR_VALID && $urandom_range(0, 1) == 1) begin m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = $urandom; end
      if (!m1_if.AR_VALID && $urandom_range(0, 1) == 1) begin m1_if.AR_VALID = 1'b1; m1_if.AR_ADDR = $urandom; end
      if (!m0_if.AR_VALID && !m1_if.AR_VALID) begin
        if ($urandom_range(0, 1) == 1) begin m1_if.AR_VALID = 1'b1; m1_if.AR_ADDR = $urandom; end
        else begin m0_if.AR_VALID = 1'b1; m0_if.AR_ADDR = $urandom; end
      end
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
